ps2_host_tx: RTL and testbench
==============================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT_CYCLES, default 5000, SHALL set the clock-inhibit hold time in CLOCK_50 cycles (100 us at 50 MHz).
REQ-002 Parameter TIMEOUT_CYCLES, default 750000, SHALL set the abort limit in CLOCK_50 cycles (15 ms), counted from clock release to the end of the frame.
REQ-003 CLOCK_50  in  1  single system clock; all logic updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 tx_data  in  8  command byte to send to the keyboard.
REQ-006 tx_valid  in  1  request to send tx_data.
REQ-007 tx_ready  out  1  high only in IDLE; a request is accepted when tx_valid && tx_ready.
REQ-008 ps2_clk_in  in  1  raw PS/2 clock line, asynchronous.
REQ-009 ps2_data_in  in  1  raw PS/2 data line, asynchronous.
REQ-010 ps2_clk_oe  out  1  1 = pull the clock line low; 0 = release it (open-collector).
REQ-011 ps2_data_oe  out  1  1 = pull the data line low; 0 = release it.
REQ-012 tx_busy  out  1  high in every state except IDLE; the receiver uses it to ignore frames.
REQ-013 tx_done  out  1  one-cycle pulse when the device acknowledges the frame.
REQ-014 tx_err  out  1  one-cycle pulse on a missing ack or a timeout.

Function
REQ-015 Both PS/2 inputs SHALL pass through 2-flop synchronizers. A falling edge is defined as the previous synchronized clock being 1 and the current one being 0; the edge register updates every cycle in every state.
REQ-016 States SHALL be: IDLE, INHIBIT, REQ, DATA, ACK, WAIT_IDLE.
REQ-017 IDLE: both oe signals are 0. On accept, latch tx_data, compute odd parity (parity = ~^tx_data), clear the counters, and go to INHIBIT.
REQ-018 INHIBIT: ps2_clk_oe=1 and ps2_data_oe=0 for exactly INHIBIT_CYCLES cycles, then go to REQ.
REQ-019 REQ: ps2_clk_oe=1 and ps2_data_oe=1 for exactly 1 cycle, then go to DATA with ps2_clk_oe=0, which releases the clock; the start bit (data low) stays driven.
REQ-020 DATA: bit index k starts at 0 and increments on each falling edge. The falling edge with k=0..7 drives data bit k (LSB first); k=8 drives the parity bit; k=9 releases data (stop bit = 1) and goes to ACK.
REQ-021 While driving a bit of value v, ps2_data_oe SHALL equal ~v.
REQ-022 ACK: ps2_data_oe=0. On the next falling edge, if synchronized data is 0, go to WAIT_IDLE; otherwise pulse tx_err and go to IDLE.
REQ-023 WAIT_IDLE: when the synchronized clock and data are both 1, pulse tx_done and go to IDLE.
REQ-024 The timeout counter SHALL run in DATA, ACK and WAIT_IDLE. On reaching TIMEOUT_CYCLES:
- release both lines in the same cycle;
- pulse tx_err;
- go to IDLE.
REQ-025 tx_done and tx_err SHALL never assert in the same cycle. A timeout takes priority over a coincident edge event.
REQ-026 tx_valid while busy SHALL be ignored and not queued. tx_data changes after accept SHALL not affect the frame.
REQ-027 Falling edges in IDLE, INHIBIT and REQ SHALL be ignored.
REQ-028 All counters SHALL saturate and never wrap. The bit counter is 4 bits; the cycle counters are sized for their parameter.

Reset
REQ-029 With reset high on a clock edge, the next-cycle outputs SHALL be:
- state IDLE;
- ps2_clk_oe=0 and ps2_data_oe=0;
- tx_ready=1;
- tx_busy=0, tx_done=0, tx_err=0.
REQ-030 Reset mid-frame SHALL release both lines within one cycle and SHALL emit no tx_done/tx_err pulse.
REQ-031 The latched data and counters SHALL be cleared on reset.

Verification
REQ-032 Send 0xED with an acking device model -> clk_oe low for 5000 cycles, then 1 REQ cycle. Driven bits on falling edges SHALL be 1,0,1,1,0,1,1,1, parity 1, stop 1. Ack 0 -> one tx_done pulse, tx_ready=1.
REQ-033 Send 0x01 -> parity bit 0 (data_oe=1 on the 9th edge). Otherwise as REQ-032.
REQ-034 Device leaves data high at the ack edge -> one tx_err pulse, no tx_done, both oe=0.
REQ-035 Device never clocks after release -> tx_err exactly TIMEOUT_CYCLES cycles after DATA entry; lines released.
REQ-036 Assert reset at bit 4 of a frame -> oe=0 next cycle, no pulses. A new tx_valid is then accepted normally.
REQ-037 Hold tx_valid high with changing tx_data during a frame -> only the first byte is sent. The next accept occurs only after tx_done.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, 10 clocked bits, ack check.
// Latency: INHIBIT_CYCLES + 1 cycles to clock release, then paced by the device clock.
// Backpressure: tx_ready only in IDLE; tx_valid while busy is dropped, not queued.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err
);
    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, REQ, DATA, ACK, WAIT_IDLE} state_t;

    state_t           state, state_nxt;
    logic             clk_meta, clk_sync, clk_prev, data_meta, data_sync;
    logic             clk_fall;
    logic [7:0]       data_q;
    logic             parity_q;
    logic             drive_q, drive_nxt;
    logic [3:0]       bit_cnt, bit_nxt;
    logic [INH_W-1:0] inh_cnt, inh_nxt;
    logic [TO_W-1:0]  to_cnt, to_nxt;
    logic             done_nxt, err_nxt, load;
    logic             timed, timeout;

    // Lines idle high, so the synchronizers reset to 1 to avoid a phantom edge.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            clk_prev  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            clk_meta  <= ps2_clk_in;
            clk_sync  <= clk_meta;
            clk_prev  <= clk_sync;
            data_meta <= ps2_data_in;
            data_sync <= data_meta;
        end
    end

    assign clk_fall = clk_prev & ~clk_sync;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state    <= IDLE;
            data_q   <= '0;
            parity_q <= 1'b0;
            drive_q  <= 1'b0;
            bit_cnt  <= '0;
            inh_cnt  <= '0;
            to_cnt   <= '0;
            tx_done  <= 1'b0;
            tx_err   <= 1'b0;
        end else begin
            state   <= state_nxt;
            drive_q <= drive_nxt;
            bit_cnt <= bit_nxt;
            inh_cnt <= inh_nxt;
            to_cnt  <= to_nxt;
            tx_done <= done_nxt;
            tx_err  <= err_nxt;
            if (load) begin
                data_q   <= tx_data;
                parity_q <= ~^tx_data;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        drive_nxt = drive_q;
        bit_nxt   = bit_cnt;
        inh_nxt   = inh_cnt;
        to_nxt    = to_cnt;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        load      = 1'b0;
        timed     = (state == DATA) || (state == ACK) || (state == WAIT_IDLE);
        timeout   = timed && (to_cnt == TO_LAST);
        if (timed && (to_cnt != TO_LAST)) to_nxt = to_cnt + TO_W'(1);

        case (state)
            IDLE: begin
                if (tx_valid) begin
                    load      = 1'b1;
                    inh_nxt   = '0;
                    to_nxt    = '0;
                    bit_nxt   = '0;
                    drive_nxt = 1'b0;
                    state_nxt = INHIBIT;
                end
            end
            INHIBIT: begin
                if (inh_cnt == INH_LAST) state_nxt = REQ;
                else                     inh_nxt   = inh_cnt + INH_W'(1);
            end
            REQ: begin
                // Start bit stays driven low once the clock is released.
                drive_nxt = 1'b1;
                to_nxt    = '0;
                bit_nxt   = '0;
                state_nxt = DATA;
            end
            DATA: begin
                if (clk_fall) begin
                    if (bit_cnt < 4'd8)       drive_nxt = ~data_q[bit_cnt[2:0]];
                    else if (bit_cnt == 4'd8) drive_nxt = ~parity_q;
                    else begin
                        drive_nxt = 1'b0;
                        state_nxt = ACK;
                    end
                    if (bit_cnt != 4'hF) bit_nxt = bit_cnt + 4'd1;
                end
            end
            ACK: begin
                if (clk_fall) begin
                    if (!data_sync) state_nxt = WAIT_IDLE;
                    else begin
                        err_nxt   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (clk_sync && data_sync) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Abort wins over any edge event seen in the same cycle.
        if (timeout) begin
            state_nxt = IDLE;
            drive_nxt = 1'b0;
            done_nxt  = 1'b0;
            err_nxt   = 1'b1;
        end
    end

    assign tx_ready    = (state == IDLE);
    assign tx_busy     = (state != IDLE);
    assign ps2_clk_oe  = (state == INHIBIT) || (state == REQ);
    assign ps2_data_oe = (state == REQ) || ((state == DATA) && drive_q);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-collector PS/2 device model.
module tb_ps2_host_tx;
    localparam int INH = 5000;
    localparam int TO  = 3000;
    localparam int H   = 20;

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b1;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
    logic       tx_busy, tx_done, tx_err;
    logic       dev_clk  = 1'b1;
    logic       dev_data = 1'b1;

    int errors = 0, checks = 0;
    int cyc = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0, acc_cnt = 0;
    int done_cyc = 0, acc_cyc = 0;
    logic busy_prev = 1'b0;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_err     (tx_err)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    always @(negedge CLOCK_50) begin
        cyc = cyc + 1;
        if (tx_done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (tx_err) err_cnt = err_cnt + 1;
        if (tx_done && tx_err) both_cnt = both_cnt + 1;
        if (tx_busy && !busy_prev) begin
            acc_cnt = acc_cnt + 1;
            acc_cyc = cyc;
        end
        busy_prev = tx_busy;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic send_byte(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
    endtask

    // Leaves the caller on the first DATA-state sample (clock just released).
    task automatic wait_release(output int inh_len, output int req_len, output logic ok);
        int n;
        n = 0;
        inh_len = 0;
        req_len = 0;
        while (!ps2_clk_oe && n < 100) begin tick(1); n++; end
        while (ps2_clk_oe && !ps2_data_oe && inh_len < 4 * INH) begin inh_len++; tick(1); end
        while (ps2_clk_oe && ps2_data_oe && req_len < 100) begin req_len++; tick(1); end
        ok = !ps2_clk_oe && ps2_data_oe;
    endtask

    task automatic device_frame(input logic ack, input int nedges, output logic [9:0] bits,
                                output logic start, output int inh_len, output int req_len,
                                output logic ok);
        bits  = '0;
        start = 1'b1;
        wait_release(inh_len, req_len, ok);
        if (!ok) return;
        tick(H);
        start = ps2_data_in;
        for (int i = 0; i < nedges && i < 10; i++) begin
            dev_clk = 1'b0;
            tick(H);
            bits[i] = ps2_data_in;
            dev_clk = 1'b1;
            if (i == 9 && ack) dev_data = 1'b0;
            tick(H);
        end
        if (nedges > 10) begin
            dev_clk = 1'b0;
            tick(H);
            dev_clk  = 1'b1;
            dev_data = 1'b1;
            tick(H);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        checks++; if (ps2_clk_oe !== 1'b0) begin errors++; $display("FAIL reset_clk_oe got=%b exp=0", ps2_clk_oe); end
        checks++; if (ps2_data_oe !== 1'b0) begin errors++; $display("FAIL reset_data_oe got=%b exp=0", ps2_data_oe); end
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", tx_ready); end
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", tx_busy); end
        checks++; if (tx_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", tx_done); end
        checks++; if (tx_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", tx_err); end
        reset = 1'b0;
        tick(3);
    endtask

    task automatic test_idle_edges();
        int d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        for (int i = 0; i < 3; i++) begin
            dev_clk = 1'b0; tick(10);
            dev_clk = 1'b1; tick(10);
        end
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL idle_edges_busy got=%b exp=0", tx_busy); end
        checks++; if ((done_cnt - d0) + (err_cnt - e0) !== 0) begin errors++; $display("FAIL idle_edges_pulses got=%0d exp=0", (done_cnt - d0) + (err_cnt - e0)); end
    endtask

    task automatic test_frame(input string name, input logic [7:0] b, input logic [9:0] exp_bits);
        logic [9:0] bits;
        logic start, ok;
        int inh, req, d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        send_byte(b);
        device_frame(1'b1, 11, bits, start, inh, req, ok);
        tick(5);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL %s_release got=%b exp=1", name, ok); end
        checks++; if (inh !== INH) begin errors++; $display("FAIL %s_inhibit_len got=%0d exp=%0d", name, inh, INH); end
        checks++; if (req !== 1) begin errors++; $display("FAIL %s_req_len got=%0d exp=1", name, req); end
        checks++; if (start !== 1'b0) begin errors++; $display("FAIL %s_start_bit got=%b exp=0", name, start); end
        checks++; if (bits !== exp_bits) begin errors++; $display("FAIL %s_bits got=%h exp=%h", name, bits, exp_bits); end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL %s_done_pulses got=%0d exp=1", name, done_cnt - d0); end
        checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL %s_err_pulses got=%0d exp=0", name, err_cnt - e0); end
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL %s_ready got=%b exp=1", name, tx_ready); end
    endtask

    task automatic test_no_ack();
        logic [9:0] bits;
        logic start, ok;
        int inh, req, d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        send_byte(8'hA5);
        device_frame(1'b0, 11, bits, start, inh, req, ok);
        tick(5);
        checks++; if (bits !== 10'h3A5) begin errors++; $display("FAIL noack_bits got=%h exp=3a5", bits); end
        checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL noack_err_pulses got=%0d exp=1", err_cnt - e0); end
        checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL noack_done_pulses got=%0d exp=0", done_cnt - d0); end
        checks++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin errors++; $display("FAIL noack_oe got=%b exp=00", {ps2_clk_oe, ps2_data_oe}); end
    endtask

    task automatic test_timeout();
        logic ok;
        int inh, req, n, d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        send_byte(8'h3C);
        wait_release(inh, req, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL timeout_release got=%b exp=1", ok); end
        n = 0;
        while (!tx_err && n < 2 * TO) begin tick(1); n++; end
        checks++; if (n !== TO) begin errors++; $display("FAIL timeout_latency got=%0d exp=%0d", n, TO); end
        checks++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin errors++; $display("FAIL timeout_oe got=%b exp=00", {ps2_clk_oe, ps2_data_oe}); end
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL timeout_ready got=%b exp=1", tx_ready); end
        tick(3);
        checks++; if (err_cnt - e0 !== 1 || done_cnt - d0 !== 0) begin errors++; $display("FAIL timeout_pulses got err=%0d done=%0d exp err=1 done=0", err_cnt - e0, done_cnt - d0); end
    endtask

    task automatic test_reset_mid_frame();
        logic [9:0] bits;
        logic start, ok;
        int inh, req, d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        send_byte(8'h45);
        device_frame(1'b1, 5, bits, start, inh, req, ok);
        checks++; if (ps2_data_oe !== 1'b1 || tx_busy !== 1'b1) begin errors++; $display("FAIL midreset_pre got oe=%b busy=%b exp oe=1 busy=1", ps2_data_oe, tx_busy); end
        reset = 1'b1;
        tick(1);
        checks++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin errors++; $display("FAIL midreset_oe got=%b exp=00", {ps2_clk_oe, ps2_data_oe}); end
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got=%b exp=0", tx_busy); end
        reset = 1'b0;
        tick(20);
        checks++; if (done_cnt - d0 !== 0 || err_cnt - e0 !== 0) begin errors++; $display("FAIL midreset_pulses got done=%0d err=%0d exp 0", done_cnt - d0, err_cnt - e0); end
        test_frame("after_reset_01", 8'h01, 10'h201);
    endtask

    task automatic test_back_to_back();
        logic [9:0] bits;
        logic start, ok, stop_chg;
        int inh, req, d0, a0;
        d0 = done_cnt;
        a0 = acc_cnt;
        stop_chg = 1'b0;
        tx_data  = 8'hED;
        tx_valid = 1'b1;
        fork
            begin
                device_frame(1'b1, 11, bits, start, inh, req, ok);
                stop_chg = 1'b1;
            end
            begin
                while (!stop_chg) begin
                    tick(1);
                    tx_data = tx_data + 8'h11;
                end
            end
        join
        tx_valid = 1'b0;
        checks++; if (bits !== 10'h3ED) begin errors++; $display("FAIL b2b_bits got=%h exp=3ed", bits); end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL b2b_done_pulses got=%0d exp=1", done_cnt - d0); end
        checks++; if (acc_cnt - a0 !== 2) begin errors++; $display("FAIL b2b_accepts got=%0d exp=2", acc_cnt - a0); end
        checks++; if (acc_cyc !== done_cyc + 1) begin errors++; $display("FAIL b2b_reaccept_cycle got=%0d exp=%0d", acc_cyc, done_cyc + 1); end
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(2);
    endtask

    initial begin
        test_reset();
        test_idle_edges();
        test_frame("frame_ed", 8'hED, 10'h3ED);
        test_frame("frame_01", 8'h01, 10'h201);
        test_no_ack();
        test_timeout();
        test_reset_mid_frame();
        test_back_to_back();
        checks++; if (both_cnt !== 0) begin errors++; $display("FAIL done_err_overlap got=%0d exp=0", both_cnt); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
